// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Shift-add multiply and restoring divide, one bit per cycle.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int W  = WIDTH;
    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    typedef enum logic {IDLE, RUN} state_t;

    state_t state, state_n;

    logic          accept, finish, wr_hi, wr_lo;
    logic [CW-1:0] cnt;
    logic          last;

    logic          is_div, neg_a, neg_r, div0;
    logic [W-1:0]  op1_q;
    logic [2*W-1:0] prod, mcand;
    logic [W-1:0]  mplier;
    logic [W-1:0]  rem, quo, dvsr;

    logic          sgn;
    logic [W-1:0]  mag1, mag2;
    logic [2*W-1:0] prod_n, prod_f;
    logic [W:0]    shifted, diff;
    logic          ge;
    logic [W-1:0]  rem_n, quo_n, rem_f, quo_f;
    logic [W-1:0]  res_hi, res_lo;

    assign last = (cnt == CW'(W - 1));
    assign busy = (state == RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        accept  = 1'b0;
        finish  = 1'b0;
        wr_hi   = 1'b0;
        wr_lo   = 1'b0;
        unique case (state)
            IDLE: begin
                if (start && !flush) begin
                    case (funct)
                        F_MULT, F_MULTU, F_DIV, F_DIVU: begin
                            accept  = 1'b1;
                            state_n = RUN;
                        end
                        F_MTHI:  wr_hi = 1'b1;
                        F_MTLO:  wr_lo = 1'b1;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                if (flush) begin
                    state_n = IDLE;
                end else if (last) begin
                    finish  = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Signed ops iterate on magnitudes; signs are fixed up at the end.
    always_comb begin
        sgn  = (funct == F_MULT) || (funct == F_DIV);
        mag1 = (sgn && op1[W-1]) ? -op1 : op1;
        mag2 = (sgn && op2[W-1]) ? -op2 : op2;
    end

    // diff[W] is the borrow: set exactly when shifted < dvsr.
    always_comb begin
        prod_n  = prod + (mplier[0] ? mcand : '0);
        shifted = {rem, quo[W-1]};
        diff    = shifted - {1'b0, dvsr};
        ge      = ~diff[W];
        rem_n   = ge ? diff[W-1:0] : shifted[W-1:0];
        quo_n   = {quo[W-2:0], ge};
        prod_f  = neg_a ? -prod_n : prod_n;
        quo_f   = neg_a ? -quo_n : quo_n;
        rem_f   = neg_r ? -rem_n : rem_n;
        if (!is_div) begin
            res_hi = prod_f[2*W-1:W];
            res_lo = prod_f[W-1:0];
        end else if (div0) begin
            res_hi = op1_q;
            res_lo = '1;
        end else begin
            res_hi = rem_f;
            res_lo = quo_f;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            is_div <= 1'b0;
            neg_a  <= 1'b0;
            neg_r  <= 1'b0;
            div0   <= 1'b0;
            op1_q  <= '0;
            prod   <= '0;
            mcand  <= '0;
            mplier <= '0;
            rem    <= '0;
            quo    <= '0;
            dvsr   <= '0;
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                cnt    <= '0;
                is_div <= (funct == F_DIV) || (funct == F_DIVU);
                neg_a  <= sgn && (op1[W-1] ^ op2[W-1]);
                neg_r  <= sgn && op1[W-1];
                div0   <= (op2 == '0);
                op1_q  <= op1;
                prod   <= '0;
                mcand  <= {{W{1'b0}}, mag1};
                mplier <= mag2;
                rem    <= '0;
                quo    <= mag1;
                dvsr   <= mag2;
            end else if (state == RUN && !flush) begin
                cnt    <= cnt + CW'(1);
                prod   <= prod_n;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                rem    <= rem_n;
                quo    <= quo_n;
            end
            if (finish) begin
                hi   <= res_hi;
                lo   <= res_lo;
                done <= 1'b1;
            end
            if (wr_hi) hi <= op1;
            if (wr_lo) lo <= op1;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit.
// Expected HI/LO pairs are queued at issue and compared on done.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [5:0]  funct = '0;
    logic [31:0] op1 = '0;
    logic [31:0] op2 = '0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int n_chk = 0;
    int n_pass = 0;
    logic [63:0] sb[$];
    logic [63:0] exp_r;
    logic [31:0] hi_m = '0;
    logic [31:0] lo_m = '0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .funct(funct),
        .op1(op1), .op2(op2), .flush(flush), .busy(busy),
        .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [63:0] model(logic [5:0] f,
                                          logic [31:0] a,
                                          logic [31:0] b);
        logic [31:0] q, r;
        case (f)
            6'h18: return longint'($signed(a)) * longint'($signed(b));
            6'h19: return {32'b0, a} * {32'b0, b};
            6'h1A: begin
                if (b == 0) return {a, 32'hFFFFFFFF};
                if (a == 32'h80000000 && b == 32'hFFFFFFFF)
                    return {32'h0, 32'h80000000};
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
                return {r, q};
            end
            6'h1B: begin
                if (b == 0) return {a, 32'hFFFFFFFF};
                return {a % b, a / b};
            end
            default: return 64'h0;
        endcase
    endfunction

    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                check("spurious_done", 64'(done), 64'h0);
            end else begin
                exp_r = sb.pop_front();
                check("result", {hi, lo}, exp_r);
            end
        end
    end

    // Caller aligns to a negedge; returns 1ns after the accepting edge.
    task automatic issue(logic [5:0] f, logic [31:0] a,
                         logic [31:0] b, bit push);
        funct = f;
        op1   = a;
        op2   = b;
        start = 1'b1;
        if (push) begin
            sb.push_back(model(f, a, b));
            {hi_m, lo_m} = model(f, a, b);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        funct = 6'($urandom);
        op1   = $urandom;
        op2   = $urandom;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy) break;
            n++;
        end
    endtask

    task automatic run(logic [5:0] f, logic [31:0] a, logic [31:0] b);
        int n;
        @(negedge clk);
        issue(f, a, b, 1'b1);
        wait_idle(n);
        check("latency", 64'(n), 64'd32);
        check("done_rise", 64'(done), 64'h1);
        @(negedge clk);
        check("done_pulse", 64'(done), 64'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int n, dc;
        logic [5:0]  f;
        logic [31:0] a, b;

        #12;
        check("rst_hi", 64'(hi), 64'h0);
        check("rst_lo", 64'(lo), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_done", 64'(done), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        run(6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF);
        check("multu_max", {hi, lo}, 64'hFFFFFFFE_00000001);
        run(6'h18, 32'hFFFFFFFD, 32'h5);
        check("mult_neg", {hi, lo}, 64'hFFFFFFFF_FFFFFFF1);
        run(6'h1A, 32'hFFFFFFF9, 32'h2);
        check("div_neg", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
        run(6'h1A, 32'h80000000, 32'hFFFFFFFF);
        check("div_ovf", {hi, lo}, 64'h00000000_80000000);
        run(6'h1B, 32'h1234, 32'h0);
        check("divu_zero", {hi, lo}, 64'h00001234_FFFFFFFF);
        run(6'h1A, 32'hFFFFFF00, 32'h0);
        check("div_zero", {hi, lo}, 64'hFFFFFF00_FFFFFFFF);

        for (int i = 0; i < 12; i++) begin
            f = 6'h18 + 6'($urandom_range(0, 3));
            a = $urandom >> $urandom_range(0, 31);
            b = ($urandom_range(0, 5) == 0) ? 32'h0
                : $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) b = -b;
            run(f, a, b);
        end

        @(negedge clk);
        issue(6'h11, 32'hAAAA5555, 32'h0, 1'b0);
        hi_m = 32'hAAAA5555;
        check("mthi", 64'(hi), 64'(hi_m));
        @(negedge clk);
        issue(6'h18, 32'h2, 32'h3, 1'b0);
        @(negedge clk);
        issue(6'h13, 32'h1, 32'h0, 1'b0);
        check("mtlo_busy_lo", 64'(lo), 64'(lo_m));
        check("mtlo_busy", 64'(busy), 64'h1);
        repeat (8) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_busy", 64'(busy), 64'h0);
        check("flush_hi", 64'(hi), 64'(hi_m));
        check("flush_lo", 64'(lo), 64'(lo_m));
        dc = 0;
        repeat (40) begin
            @(negedge clk);
            dc += int'(done);
        end
        check("flush_no_done", 64'(dc), 64'h0);

        flush = 1'b1;
        issue(6'h13, 32'h5A5A, 32'h0, 1'b0);
        flush = 1'b0;
        check("flush_start_lo", 64'(lo), 64'(lo_m));
        check("flush_start_busy", 64'(busy), 64'h0);

        @(negedge clk);
        issue(6'h1B, 32'd100, 32'd7, 1'b0);
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        hi_m = '0;
        lo_m = '0;
        check("arst_hi", 64'(hi), 64'h0);
        check("arst_lo", 64'(lo), 64'h0);
        check("arst_busy", 64'(busy), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        @(negedge clk);
        issue(6'h19, 32'd2, 32'd3, 1'b1);
        wait_idle(n);
        check("b2b_lat1", 64'(n), 64'd32);
        check("b2b_lo1", 64'(lo), 64'd6);
        issue(6'h19, 32'd4, 32'd5, 1'b1);
        check("b2b_done_clr", 64'(done), 64'h0);
        wait_idle(n);
        check("b2b_lat2", 64'(n), 64'd32);
        check("b2b_lo2", 64'(lo), 64'd20);
        repeat (2) @(negedge clk);
        check("sb_empty", 64'(sb.size()), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
